step_display_scanner: RTL and testbench
=======================================

// Module: step_display_scanner
// PURPOSE
//  Upstream feeder for the 4-digit active-low 7-segment path of the step-count display.
//  Takes a binary count and converts it to 4 BCD digits with a sequential double-dabble.
//  Time-multiplexes the digits: one 4-bit BCD digit on digit_out plus its anode select.
//  digit_out goes straight to the hex-to-7-segment decoder; an goes to the board anodes.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot (100 MHz -> 1 kHz/digit); must be >= 2
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst_n      in   1   synchronous reset, active-low
//  value_in   in   14  binary value to display; sampled on an accepted load
//  load       in   1   request conversion of value_in; accepted only in IDLE
//  busy       out  1   high while a conversion is in progress
//  done       out  1   one-cycle pulse when new digits are committed to the display
//  digit_out  out  4   BCD digit (0-9) for the currently selected slot
//  an         out  4   anode selects, active-low; an[0] = ones digit, an[3] = thousands
// BEHAVIOUR
//  Reset (rst_n=0 at an edge, any state, including mid-conversion):
//   - state=IDLE; busy=0; done=0.
//   - Display register = 0000; scan index=0; refresh counter=0.
//   - an=4'b1110; digit_out=4'd0.
//  Clamp: value_in > 9999 is captured as 9999 (14'd9999).
//  FSM IDLE -> CONV -> COMMIT -> IDLE:
//   - IDLE: load=1 at edge E0 captures the clamped value and clears the BCD accumulator
//     (16 bits). Go to CONV; busy=1 from E0.
//   - CONV: edges E1..E14, one per bit, MSB first. At each edge, every BCD nibble >= 5
//     gets +3, then {bcd,bin} shifts left 1. After E14, go to COMMIT.
//   - COMMIT: at E15, the display register takes the accumulator. done=1 for the cycle
//     after E15. busy=0 from E15. Go to IDLE.
//   - Total: busy high for exactly 15 cycles. New digits appear on the first scan slot
//     after E15.
//   - load while busy (CONV/COMMIT): ignored, not queued.
//   - load at the same edge as the COMMIT->IDLE transition: ignored. The next edge
//     with load=1 in IDLE is accepted.
//  The display register holds its value until the next COMMIT. The scan keeps running
//  during conversion and shows the old digits.
//  Scan:
//   - The refresh counter counts 0..REFRESH_DIV-1, then wraps.
//   - On wrap, index advances 0->1->2->3->0.
//   - an = ~(4'b0001 << index); digit_out = display[index*4 +: 4].
//   - Both are registered and change together on the wrap edge; no glitch between
//     an and digit_out.
//  Widths: value_in is unsigned 14 bits. The accumulator is 4x4 bits; no nibble exceeds 9
//  after COMMIT.
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN defined:
//   - A slot whose digit and all higher digits are 0 drives an=4'b1111 (blanked) for
//     that slot period.
//   - digit_out still shows 0 in a blanked slot.
//   - Slot 0 (ones) is never blanked, so value 0 shows a single "0".
//   - Reset value unchanged (an=4'b1110).
//  LEAD_ZERO_BLANK_EN undefined: all four slots always drive; leading zeros are shown.
// TESTING (simulate with REFRESH_DIV=4)
//  1. Reset: hold rst_n=0 for 3 cycles -> an=1110, digit_out=0, busy=0, done=0;
//     an then cycles 1110,1101,1011,0111 every 4 clk.
//  2. value_in=1234, load pulse -> busy high exactly 15 cycles, done pulse once;
//     scan then gives digit_out 4,3,2,1 for an 1110,1101,1011,0111.
//  3. value_in=16383 -> digits 9,9,9,9. value_in=0 -> 0,0,0,0.
//     value_in=9999 -> 9,9,9,9 (clamp boundary).
//  4. load 1234, then pulse load with value_in=5678 at cycles 5 and 15 of busy ->
//     both ignored; display=1234. The next load in IDLE converts 5678.
//  5. load 4321, assert rst_n=0 at busy cycle 7 -> next cycle: busy=0, display 0000,
//     no done pulse; a subsequent load of 42 converts normally.
//  6. LEAD_ZERO_BLANK_EN defined, value 7 -> an 1110 with digit 7, then three slots
//     with an=1111. Undefined -> 0,0,0,7 all driven.

Source files
------------

// File: rtl/step_display_scanner.sv
// step_display_scanner: 14-bit binary to 4-digit BCD (sequential double-dabble)
// plus a registered 4-digit active-low anode scan for a 7-segment display.
// Ports: clk, rst_n (sync, active-low), value_in[13:0], load -> busy, done,
//        digit_out[3:0] (BCD of selected slot), an[3:0] (active-low, an[0]=ones).
// Optional build macro: LEAD_ZERO_BLANK_EN blanks leading-zero slots (an=1111).
module step_display_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit_out,
    output logic [3:0]  an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONV   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [13:0] MAX_VAL  = 14'd9999;
    localparam logic [3:0]  LAST_BIT = 4'd13;

    logic [1:0]    state;
    logic [13:0]   bin;
    logic [15:0]   bcd;
    logic [15:0]   adjusted;
    logic [3:0]    bit_cnt;
    logic [15:0]   display;
    logic [15:0]   display_next;
    logic [13:0]   clamped;

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    scan_idx;
    logic [1:0]    next_idx;
    logic          wrap;
    logic          blank;
    logic [3:0]    next_digit;
    logic [3:0]    next_an;

    // Add 3 to every nibble that is 5 or more, ahead of the shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int k = 0; k < 4; k++) begin
            if (r[k*4 +: 4] >= 4'd5) begin
                r[k*4 +: 4] = r[k*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        adjusted = dabble_adjust(bcd);
        clamped  = (value_in > MAX_VAL) ? MAX_VAL : value_in;
    end

    assign busy = (state != IDLE);

    // Conversion FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            bin     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            display <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin     <= clamped;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bcd     <= {adjusted[14:0], bin[13]};
                    bin     <= {bin[12:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    display <= bcd;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A slot that opens on the commit edge already shows the new digits.
    assign display_next = (state == COMMIT) ? bcd : display;

    assign wrap     = (refresh_cnt == CW'(REFRESH_DIV - 1));
    assign next_idx = scan_idx + 2'd1;

    always_comb begin
        next_digit = display_next[{next_idx, 2'b00} +: 4];
        blank      = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        case (next_idx)
            2'd1:    blank = (display_next[15:4] == 12'd0);
            2'd2:    blank = (display_next[15:8] == 8'd0);
            2'd3:    blank = (display_next[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`endif
        next_an = blank ? 4'b1111 : ~(4'b0001 << next_idx);
    end

    // Scan: anode and digit are latched together on the wrap edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
            an          <= 4'b1110;
            digit_out   <= 4'd0;
        end else if (wrap) begin
            refresh_cnt <= '0;
            scan_idx    <= next_idx;
            an          <= next_an;
            digit_out   <= next_digit;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_step_display_scanner.sv
// Randomised bench for step_display_scanner against a decimal-arithmetic model.
// Build with or without LEAD_ZERO_BLANK_EN; the model follows the same macro.
module tb_step_display_scanner;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [13:0] value_in;
    logic        load;
    logic        busy;
    logic        done;
    logic [3:0]  digit_out;
    logic [3:0]  an;

    int n_cmp;
    int n_bad;

    // reference model state
    int m_left;
    int m_pending;
    int m_disp;
    int m_done;
    int m_cnt;
    int m_idx;
    int m_digit;
    int m_an;

    step_display_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value_in  (value_in),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .digit_out (digit_out),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int p10(input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int clamp(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    task automatic model_edge();
        int blank;
        if (!rst_n) begin
            m_left  = 0;
            m_done  = 0;
            m_disp  = 0;
            m_cnt   = 0;
            m_idx   = 0;
            m_an    = 4'b1110;
            m_digit = 0;
        end else begin
            m_done = 0;
            if (m_left == 0) begin
                if (load) begin
                    m_left    = 15;
                    m_pending = clamp(int'(value_in));
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_disp = m_pending;
                    m_done = 1;
                end
            end
            if (m_cnt == DIV - 1) begin
                m_cnt   = 0;
                m_idx   = (m_idx + 1) % 4;
                m_digit = (m_disp / p10(m_idx)) % 10;
                blank   = 0;
`ifdef LEAD_ZERO_BLANK_EN
                blank = (m_idx != 0) && (m_disp < p10(m_idx));
`endif
                m_an = blank ? 15 : ((~(1 << m_idx)) & 15);
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("busy", int'(busy), int'(m_left > 0));
        check("done", int'(done), m_done);
        check("an", int'(an), m_an);
        check("digit_out", int'(digit_out), m_digit);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input int v);
        value_in = 14'(v);
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    int busy_cycles;
    int done_pulses;

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        m_left   = 0;
        m_pending = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = '0;

        // reset and free-running scan
        run(3);
        check("reset_an", int'(an), 4'b1110);
        check("reset_digit", int'(digit_out), 0);
        rst_n = 1'b1;
        run(20);

        // 1234: busy for exactly 15 cycles, a single done
        busy_cycles = 0;
        done_pulses = 0;
        do_load(1234);
        for (int i = 0; i < 40; i++) begin
            step();
            busy_cycles += int'(busy);
            done_pulses += int'(done);
        end
        check("busy_len", busy_cycles + 1, 15);
        check("done_count", done_pulses, 1);

        // full-scale, zero and clamp boundary
        do_load(16383);
        run(40);
        check("clamp_disp", m_disp, 9999);
        do_load(0);
        run(40);
        do_load(9999);
        run(40);

        // loads during busy are dropped
        do_load(1234);
        for (int i = 1; i <= 16; i++) begin
            value_in = 14'd5678;
            load     = (i == 5 || i == 15);
            step();
        end
        load = 1'b0;
        run(20);
        check("ignored_disp", m_disp, 1234);
        do_load(5678);
        run(40);

        // reset mid-conversion
        do_load(4321);
        run(6);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(20);
        do_load(42);
        run(40);

        // small value exercises leading-zero handling
        do_load(7);
        run(40);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            value_in = ($urandom_range(0, 1) == 1) ?
                       14'($urandom_range(0, 120)) : 14'($urandom_range(0, 16383));
            load  = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        load  = 1'b0;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
